// File: rtl/traffic_pkg.sv
// Shared types, fault codes and lamp encoding for the traffic light safety checker.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    BAD    = 2'd3
  } light_e;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    MONITOR = 2'd1,
    FAULT   = 2'd2
  } chk_state_e;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_BAD_ENC   = 3'd1;
  localparam logic [2:0] FC_BAD_TRANS = 3'd2;
  localparam logic [2:0] FC_SHORT     = 3'd3;
  localparam logic [2:0] FC_LONG      = 3'd4;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Lamp drive is {R,Y,G}; an illegal encoding lights nothing.
  function automatic logic [2:0] lamp_onehot(light_e l);
    case (l)
      RED:     return 3'b100;
      YELLOW:  return 3'b010;
      GREEN:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic legal_step(light_e from, light_e to);
    return ((from == RED)    && (to == GREEN))  ||
           ((from == GREEN)  && (to == YELLOW)) ||
           ((from == YELLOW) && (to == RED));
  endfunction

endpackage

// File: rtl/traffic_flasher.sv
// Fault-mode flash generator: flash_on toggles every FLASH_HALF enabled cycles.
module traffic_flasher #(
  parameter int FLASH_HALF = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic start,
  output logic flash_on_nxt
);

  localparam int CW = $clog2(FLASH_HALF + 1);
  localparam logic [CW-1:0] LAST = CW'(FLASH_HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          on_q, on_d;

  always_comb begin
    cnt_d = cnt_q;
    on_d  = on_q;
    if (start) begin
      cnt_d = '0;
      on_d  = 1'b1;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        on_d  = ~on_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      on_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      on_q  <= on_d;
    end
  end

  // Exposed pre-register so the registered lamp output lines up with the toggle.
  assign flash_on_nxt = on_d;

endmodule

// File: rtl/traffic_light_checker.sv
// Safety checker behind the traffic controller: validates colour sequence and dwell
// times, drives the lamps, and latches a fault with flashing RED until cleared.
module traffic_light_checker
  import traffic_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int MIN_GREEN  = 20,
  parameter int MAX_GREEN  = 200,
  parameter int MIN_YELLOW = 5,
  parameter int MAX_YELLOW = 20,
  parameter int MIN_RED    = 20,
  parameter int MAX_RED    = 200,
  parameter int FLASH_HALF = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] light_in,
  input  logic       clr_fault,
  output logic [2:0] lamp_out,
  output logic       fault,
  output logic [2:0] fault_code
);

  function automatic logic [CNT_W-1:0] min_for(light_e l);
    case (l)
      GREEN:   return CNT_W'(MIN_GREEN);
      YELLOW:  return CNT_W'(MIN_YELLOW);
      default: return CNT_W'(MIN_RED);
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] max_for(light_e l);
    case (l)
      GREEN:   return CNT_W'(MAX_GREEN);
      YELLOW:  return CNT_W'(MAX_YELLOW);
      default: return CNT_W'(MAX_RED);
    endcase
  endfunction

  chk_state_e       state_q, state_d;
  light_e           prev_q, prev_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [2:0]       lamp_q, lamp_d;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d;

  light_e           lin;
  logic [CNT_W-1:0] dwell_inc;
  logic [2:0]       code_new;
  logic             flash_start;
  logic             flash_en;
  logic             flash_on_nxt;

  assign lin       = light_e'(light_in);
  assign dwell_inc = (&dwell_q) ? dwell_q : dwell_q + 1'b1;
  assign flash_en  = (state_q == FAULT);

  traffic_flasher #(
    .FLASH_HALF(FLASH_HALF)
  ) u_flasher (
    .clk          (clk),
    .reset        (reset),
    .en           (flash_en),
    .start        (flash_start),
    .flash_on_nxt (flash_on_nxt)
  );

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    dwell_d     = dwell_q;
    lamp_d      = lamp_q;
    fault_d     = fault_q;
    code_d      = code_q;
    code_new    = FC_NONE;
    flash_start = 1'b0;

    case (state_q)
      INIT: begin
        lamp_d = LAMP_RED;
        if (lin == BAD) begin
          code_new = FC_BAD_ENC;
        end else if (lin == RED) begin
          state_d = MONITOR;
          prev_d  = RED;
          dwell_d = CNT_W'(1);
        end
      end

      MONITOR: begin
        lamp_d = lamp_onehot(lin);
        // Branch order encodes fault priority: encoding > transition > short > long.
        if (lin == BAD) begin
          code_new = FC_BAD_ENC;
        end else if (lin == prev_q) begin
          dwell_d = dwell_inc;
          if (dwell_inc > max_for(prev_q)) code_new = FC_LONG;
        end else if (!legal_step(prev_q, lin)) begin
          code_new = FC_BAD_TRANS;
        end else if (dwell_q < min_for(prev_q)) begin
          code_new = FC_SHORT;
        end else begin
          prev_d  = lin;
          dwell_d = CNT_W'(1);
        end
      end

      FAULT: begin
        lamp_d = flash_on_nxt ? LAMP_RED : LAMP_OFF;
        if (clr_fault && (lin == RED)) begin
          state_d = INIT;
          fault_d = 1'b0;
          code_d  = FC_NONE;
          lamp_d  = LAMP_RED;
        end
      end

      default: begin
        state_d = INIT;
        lamp_d  = LAMP_RED;
      end
    endcase

    // Only INIT and MONITOR raise codes, so a latched code is never overwritten.
    if (code_new != FC_NONE) begin
      state_d     = FAULT;
      fault_d     = 1'b1;
      code_d      = code_new;
      lamp_d      = LAMP_RED;
      flash_start = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      prev_q  <= RED;
      dwell_q <= '0;
      lamp_q  <= LAMP_RED;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      dwell_q <= dwell_d;
      lamp_q  <= lamp_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  assign lamp_out   = lamp_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_light_checker.sv
// Directed bench for traffic_light_checker with short dwell limits and FLASH_HALF=3.
module tb_traffic_light_checker;
  import traffic_pkg::*;

  logic       clk;
  logic       reset;
  logic [1:0] light_in;
  logic       clr_fault;
  logic [2:0] lamp_out;
  logic       fault;
  logic [2:0] fault_code;

  int n_chk  = 0;
  int n_pass = 0;

  traffic_light_checker #(
    .CNT_W      (16),
    .MIN_GREEN  (4),
    .MAX_GREEN  (10),
    .MIN_YELLOW (2),
    .MAX_YELLOW (4),
    .MIN_RED    (4),
    .MAX_RED    (10),
    .FLASH_HALF (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .light_in   (light_in),
    .clr_fault  (clr_fault),
    .lamp_out   (lamp_out),
    .fault      (fault),
    .fault_code (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic apply(input logic [1:0] l, input logic c);
    light_in  = l;
    clr_fault = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    light_in  = RED;
    clr_fault = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic reds(input int n);
    for (int i = 0; i < n; i++) begin
      apply(RED, 1'b0);
      chk("red_lamp", {5'b0, lamp_out}, 8'b100);
    end
  endtask

  initial begin
    reset     = 1'b0;
    light_in  = RED;
    clr_fault = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lamp", {5'b0, lamp_out}, 8'b100);
    chk("rst_fault", {7'b0, fault}, 8'd0);
    chk("rst_code", {5'b0, fault_code}, 8'd0);
    reset = 1'b1;

    // 1: full legal cycle, lamps lag input by one cycle
    reds(5);
    for (int i = 0; i < 5; i++) begin
      apply(GREEN, 1'b0);
      chk("t1_green", {5'b0, lamp_out}, 8'b001);
    end
    for (int i = 0; i < 3; i++) begin
      apply(YELLOW, 1'b0);
      chk("t1_yellow", {5'b0, lamp_out}, 8'b010);
    end
    reds(5);
    chk("t1_fault", {7'b0, fault}, 8'd0);
    chk("t1_code", {5'b0, fault_code}, 8'd0);

    // 2: GREEN->RED is illegal; then flash 3 on / 3 off
    do_reset();
    reds(5);
    apply(GREEN, 1'b0);
    chk("t2_green", {5'b0, lamp_out}, 8'b001);
    apply(RED, 1'b0);
    chk("t2_fault", {7'b0, fault}, 8'd1);
    chk("t2_code", {5'b0, fault_code}, 8'd2);
    chk("t2_lamp0", {5'b0, lamp_out}, 8'b100);
    for (int i = 1; i <= 7; i++) begin
      apply(RED, 1'b0);
      chk("t2_flash", {5'b0, lamp_out}, (((i / 3) % 2) == 0) ? 8'b100 : 8'b000);
    end
    chk("t2_code_hold", {5'b0, fault_code}, 8'd2);

    // 3: short GREEN, clear ignored on GREEN, honoured on RED
    do_reset();
    reds(5);
    apply(GREEN, 1'b0);
    apply(GREEN, 1'b0);
    chk("t3_nofault", {7'b0, fault}, 8'd0);
    apply(YELLOW, 1'b0);
    chk("t3_fault", {7'b0, fault}, 8'd1);
    chk("t3_code", {5'b0, fault_code}, 8'd3);
    apply(GREEN, 1'b1);
    chk("t3_clr_ign_f", {7'b0, fault}, 8'd1);
    chk("t3_clr_ign_c", {5'b0, fault_code}, 8'd3);
    apply(RED, 1'b1);
    chk("t3_clr_f", {7'b0, fault}, 8'd0);
    chk("t3_clr_c", {5'b0, fault_code}, 8'd0);
    chk("t3_clr_lamp", {5'b0, lamp_out}, 8'b100);
    apply(GREEN, 1'b0);
    chk("t3_init_lamp", {5'b0, lamp_out}, 8'b100);
    chk("t3_init_f", {7'b0, fault}, 8'd0);

    // 4: GREEN held past MAX; later bad encoding keeps the first code
    do_reset();
    reds(5);
    for (int i = 1; i <= 10; i++) begin
      apply(GREEN, 1'b0);
      chk("t4_green_ok", {7'b0, fault}, 8'd0);
    end
    apply(GREEN, 1'b0);
    chk("t4_fault", {7'b0, fault}, 8'd1);
    chk("t4_code", {5'b0, fault_code}, 8'd4);
    apply(2'b11, 1'b0);
    chk("t4_code_keep", {5'b0, fault_code}, 8'd4);

    // 5: bad encoding beats short dwell; also bad encoding in INIT
    do_reset();
    reds(5);
    apply(GREEN, 1'b0);
    apply(2'b11, 1'b0);
    chk("t5_code", {5'b0, fault_code}, 8'd1);
    chk("t5_lamp", {5'b0, lamp_out}, 8'b100);
    do_reset();
    apply(2'b11, 1'b0);
    chk("t5_init_code", {5'b0, fault_code}, 8'd1);
    chk("t5_init_f", {7'b0, fault}, 8'd1);

    // 6: async reset while flashing
    do_reset();
    reds(5);
    apply(GREEN, 1'b0);
    apply(RED, 1'b0);
    for (int i = 1; i <= 4; i++) apply(RED, 1'b0);
    chk("t6_midflash", {5'b0, lamp_out}, 8'b000);
    reset = 1'b0;
    #1;
    chk("t6_rst_lamp", {5'b0, lamp_out}, 8'b100);
    chk("t6_rst_fault", {7'b0, fault}, 8'd0);
    chk("t6_rst_code", {5'b0, fault_code}, 8'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
